reg_alu_seq: RTL and testbench

- Instruction sequencer that sits directly upstream of the register-file/ALU datapath.
- Buffers 16-bit instruction words in a small FIFO and decodes them one per cycle.
- Drives the datapath control and data inputs: sel, wr, op, rd_addr_a, rd_addr_b, wr_addr and d_in.
- Handles immediate loads, ALU ops, NOPs and a sticky HALT.

---
 rtl/reg_alu_seq.sv | 155 +++++++++++++++
 tb/tb_reg_alu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: instruction sequencer that feeds the register-file/ALU datapath.
// A small FIFO buffers 16-bit instruction words. One word is decoded per cycle
// into registered datapath controls. A HALT instruction is sticky until reset.
// Optional feature: define REG_ALU_SEQ_RETIRE_CNT_EN to add the 16-bit
// 'retired' output, which counts issued LOAD and ALU instructions.
module reg_alu_seq #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        sel,
  output logic        wr,
  output logic [1:0]  op,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  output logic [2:0]  wr_addr,
  output logic [15:0] d_in,
  output logic        busy,
`ifdef REG_ALU_SEQ_RETIRE_CNT_EN
  output logic [15:0] retired,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HALT} state_t;

  localparam logic [1:0] T_LOAD = 2'b00;
  localparam logic [1:0] T_ALU  = 2'b01;
  localparam logic [1:0] T_NOP  = 2'b10;
  localparam logic [1:0] T_HALT = 2'b11;

  // Bundle of the registered datapath controls, so hold/clear is one assignment.
  typedef struct packed {
    logic        sel;
    logic        wr;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
  } ctl_t;

  state_t        state, state_nxt;
  ctl_t          ctl, ctl_nxt;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, push, pop;
  logic [15:0]   head;

  assign full        = (count == (AW+1)'(DEPTH));
  assign halted      = (state == S_HALT);
  assign instr_ready = !full && !halted && !reset;
  assign push        = instr_valid && instr_ready;
  // A pop uses only the count registered before this edge. A word pushed into
  // an empty FIFO therefore waits one edge; there is no bypass path.
  assign pop         = (state != S_HALT) && (count != '0);
  assign head        = mem[rptr];
  assign busy        = (state == S_EXEC) || (count != '0);

  // FIFO storage. The contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= instr_in;
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // State register and registered datapath controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ctl   <= '0;
    end else begin
      state <= state_nxt;
      ctl   <= ctl_nxt;
    end
  end

  // Decode the head word. Outputs hold by default, and wr is a one-cycle strobe.
  always_comb begin
    state_nxt  = state;
    ctl_nxt    = ctl;
    ctl_nxt.wr = 1'b0;
    case (state)
      S_HALT: state_nxt = S_HALT;
      default: begin
        if (pop) begin
          state_nxt = S_EXEC;
          case (head[15:14])
            T_LOAD: begin
              ctl_nxt.sel       = 1'b0;
              ctl_nxt.wr        = 1'b1;
              ctl_nxt.op        = 2'b00;
              ctl_nxt.rd_addr_a = 3'd0;
              ctl_nxt.rd_addr_b = 3'd0;
              ctl_nxt.wr_addr   = head[11:9];
              ctl_nxt.d_in      = {7'd0, head[8:0]};
            end
            T_ALU: begin
              ctl_nxt.sel       = 1'b1;
              ctl_nxt.wr        = 1'b1;
              ctl_nxt.op        = head[13:12];
              ctl_nxt.rd_addr_a = head[8:6];
              ctl_nxt.rd_addr_b = head[5:3];
              ctl_nxt.wr_addr   = head[11:9];
              ctl_nxt.d_in      = 16'd0;
            end
            T_NOP:   state_nxt = S_EXEC;
            T_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_EXEC;
          endcase
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  assign sel       = ctl.sel;
  assign wr        = ctl.wr;
  assign op        = ctl.op;
  assign rd_addr_a = ctl.rd_addr_a;
  assign rd_addr_b = ctl.rd_addr_b;
  assign wr_addr   = ctl.wr_addr;
  assign d_in      = ctl.d_in;

`ifdef REG_ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] retired_q;

  // Count issued register writes. LOAD and ALU both have a clear bit 15.
  always_ff @(posedge clk) begin
    if (reset)                 retired_q <= 16'd0;
    else if (pop && !head[15]) retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_reg_alu_seq.sv
// Scoreboard bench for reg_alu_seq. The stimulus pushes the expected datapath
// controls when a word is accepted. A negedge monitor compares them on each wr strobe.
module tb_reg_alu_seq;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, sel, wr, busy, halted;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_in;
`ifdef REG_ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  reg_alu_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .sel(sel), .wr(wr), .op(op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
    .d_in(d_in), .busy(busy),
`ifdef REG_ALU_SEQ_RETIRE_CNT_EN
    .retired(retired),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [27:0] sb[$];   // {sel, op, a, b, wa, d_in}
  bit halt_seen = 0;
  int wr_cnt = 0, run = 0, max_run = 0;
  int ret_exp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Expected datapath controls for a LOAD or ALU word, taken from the format table.
  function automatic logic [27:0] expect_of(input logic [15:0] w);
    if (w[15:14] == 2'b00)
      return {1'b0, 2'b00, 3'd0, 3'd0, w[11:9], 7'd0, w[8:0]};
    else
      return {1'b1, w[13:12], w[8:6], w[5:3], w[11:9], 16'd0};
  endfunction

  // Reference model for acceptance. Words after an accepted HALT never issue.
  task automatic model_accept(input logic [15:0] w);
    if (!halt_seen) begin
      if (!w[15]) sb.push_back(expect_of(w));
      else if (w[15:14] == 2'b11) halt_seen = 1;
    end
  endtask

  // Monitor: every wr strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr) begin
        wr_cnt++; run++;
        if (run > max_run) max_run = run;
        if (sb.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else chk("issue", {4'd0, sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in}, {4'd0, sb.pop_front()});
`ifdef REG_ALU_SEQ_RETIRE_CNT_EN
        ret_exp++;
        chk("retired", {16'd0, retired}, ret_exp);
`endif
      end else run = 0;
    end
  end

  // All stimulus starts 1 time unit after a rising edge.
  task automatic send(input logic [15:0] w);
    int g = 0;
    instr_in = w; instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && g < 100) begin g++; @(negedge clk); end
    chk("send_timeout", g >= 100, 0);
    @(posedge clk);
    if (g < 100) model_accept(w);
    #1 instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit with_word);
    reset = 1'b1;
    instr_valid = with_word; instr_in = 16'h0A07;
    #1 chk("ready_in_reset", instr_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0; instr_valid = 1'b0;
    sb.delete(); halt_seen = 0; wr_cnt = 0; run = 0; max_run = 0; ret_exp = 0;
  endtask

  task automatic chk_reset_state(input string nm);
    @(negedge clk);
    chk(nm, {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, halted, busy}, 0);
    chk({nm, "_ready"}, instr_ready, 1);
`ifdef REG_ALU_SEQ_RETIRE_CNT_EN
    chk({nm, "_retired"}, {16'd0, retired}, 0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    @(negedge clk);
    while (busy && g < 60) begin g++; @(negedge clk); end
    chk({nm, "_idle_timeout"}, g >= 60, 0);
    chk({nm, "_drained"}, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_halted(input string nm);
    int g = 0;
    @(negedge clk);
    while (!halted && g < 60) begin g++; @(negedge clk); end
    chk({nm, "_halt_timeout"}, g >= 60, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [15:0] w;
    logic [31:0] r;
    idle(2);
    do_reset(1'b1);
    chk_reset_state("reset0");

    // 1: single LOAD, then return to idle.
    send(16'h0A05);
    @(negedge clk); chk("t1_not_yet", wr, 0);
    @(negedge clk);
    chk("t1_wr", wr, 1);
    chk("t1_fields", {sel, wr_addr, d_in}, {1'b0, 3'd5, 16'h0005});
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_wr_drop", wr, 0);
    chk("t1_idle", busy, 0);
    @(posedge clk); #1;

    // 2: ALU decode.
    send(16'h5A88);
    wait_idle("t2");
    chk("t2_fields", {sel, op, wr_addr, rd_addr_a, rd_addr_b}, {1'b1, 2'b01, 3'd5, 3'd2, 3'd1});

    // 3: a leading HALT blocks pops, and valid is held for DEPTH+2 words.
    do_reset(1'b0);
    acc = 0;
    instr_in = 16'hC000; instr_valid = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      @(negedge clk);
      if (k > 1) chk("t3_ready_low", instr_ready, 0);
      r[0] = instr_ready;
      @(posedge clk);
      if (r[0]) begin acc++; model_accept(instr_in); end
      #1 instr_in = 16'h0200 | 16'(k + 1);
    end
    instr_valid = 1'b0;
    chk("t3_accepted", acc, 2);
    @(negedge clk);
    chk("t3_state", {halted, busy, instr_ready}, 3'b110);
    chk("t3_no_wr", wr_cnt, 0);
    @(posedge clk); #1;

    // 4: eight back-to-back LOADs.
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) send(16'((i % 8) << 9) | 16'(i));
    wait_idle("t4");
    chk("t4_run", max_run, 8);
    chk("t4_count", wr_cnt, 8);

    // 5: LOAD, NOP, HALT, LOAD.
    do_reset(1'b0);
    send(16'h0411); send(16'h8000); send(16'hC000); send(16'h0622);
    wait_halted("t5");
    idle(5);
    @(negedge clk);
    chk("t5_wr_pulses", wr_cnt, 1);
    chk("t5_halted", halted, 1);
    chk("t5_sb", sb.size(), 0);
    @(posedge clk); #1;
    do_reset(1'b0);
    chk_reset_state("t5_reset");

    // 6: reset mid-stream while wr is high.
    send(16'h0201); send(16'h0402); send(16'h5E10);
    chk("t6_wr_high", wr, 1);
    do_reset(1'b1);
    chk_reset_state("t6_reset");

    // Random stream, with an occasional HALT followed by a reset.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      w = 16'($urandom);
      if (r < 45) w[15:14] = 2'b00;
      else if (r < 85) w[15:14] = 2'b01;
      else if (r < 97) w[15:14] = 2'b10;
      else w[15:14] = 2'b11;
      send(w);
      if (w[15:14] == 2'b11) begin
        wait_halted("rnd");
        chk("rnd_halt_sb", sb.size(), 0);
        do_reset($urandom_range(0, 1));
      end else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    wait_idle("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
